// File: rtl/chu_capture_pkg.sv
// Shared types and constants for the VGA line-capture core: FSM states,
// register map, STATUS layout and the CRC-16-CCITT step used when CAPTURE_CRC_EN is set.
package chu_capture_pkg;

  localparam int CD_DEF   = 12;
  localparam int HMAX_DEF = 640;
  localparam int VMAX_DEF = 480;

  localparam int COORD_W = 11;
  localparam int ADDR_W  = 14;
  localparam int DATA_W  = 32;
  localparam int TGT_W   = 10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMED     = 3'd1,
    ST_WAIT_LINE = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_DONE      = 3'd4
  } cap_state_e;

  localparam logic [12:0] REG_CTRL   = 13'd0;
  localparam logic [12:0] REG_STATUS = 13'd1;
  localparam logic [12:0] REG_CLEAR  = 13'd2;

  localparam int ST_DONE_BIT  = 0;
  localparam int ST_BUSY_BIT  = 1;
  localparam int ST_STATE_LSB = 2;
  localparam int ST_COUNT_LSB = 5;
  localparam int ST_CRC_LSB   = 16;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // One 16-bit word folded into the CRC, most significant bit first.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/chu_vga_capture_core_if.sv
// Slot bus between the video-slot controller (master) and the capture core (slave).
interface chu_vga_capture_core_if;
  import chu_capture_pkg::*;

  logic              cs;
  logic              write;
  logic              read;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;

  modport master (output cs, write, read, addr, wr_data, input  rd_data);
  modport slave  (input  cs, write, read, addr, wr_data, output rd_data);
endinterface

// File: rtl/capture_line_ram.sv
// Simple dual-port line buffer: one write port, one registered read port,
// read-before-write when both ports hit the same word.
module capture_line_ram #(
  parameter int W     = 12,
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rq
);
  logic [W-1:0] mem [DEPTH];

  // NOTE: the array is deliberately not reset so it maps onto block RAM;
  // contents survive reset and are only meaningful once written.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make the read see the pre-write word on a collision.
    if (we) mem[wa] <= wd;
    if (re) rq <= mem[ra];
  end
endmodule

// File: rtl/chu_vga_capture_core.sv
// Captures one chosen active line of the pixel stream into a line buffer while
// passing the stream through untouched. Optional line CRC: define CAPTURE_CRC_EN.
module chu_vga_capture_core
  import chu_capture_pkg::*;
#(
  parameter int CD   = CD_DEF,
  parameter int HMAX = HMAX_DEF,
  parameter int VMAX = VMAX_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               si_valid,
  input  logic               si_frame_start,
  input  logic [CD-1:0]      si_rgb,
  output logic [CD-1:0]      so_rgb,
  chu_vga_capture_core_if.slave bus
);
  localparam int IDX_W = $clog2(HMAX);
  localparam int CNT_W = $clog2(HMAX + 1);

  cap_state_e        state_q, state_d;
  logic [TGT_W-1:0]  target_q;
  logic [CNT_W-1:0]  count_q;
  logic [15:0]       crc_w;
  logic              cap_we, arm_ok;
  logic              reg_wr, arm_wr, clr_wr, rd_req, buf_rd;
  logic              target_oor;
  logic [DATA_W-1:0] status_w, reg_rd_q;
  logic              rd_buf_q;
  logic [CD-1:0]     buf_q;
  logic              unused_bits;

  assign so_rgb = si_rgb;

  assign reg_wr = bus.cs && bus.write && !bus.addr[13];
  assign arm_wr = reg_wr && (bus.addr[12:0] == REG_CTRL) && bus.wr_data[0];
  assign clr_wr = reg_wr && (bus.addr[12:0] == REG_CLEAR);
  assign rd_req = bus.cs && bus.read;
  assign buf_rd = rd_req && bus.addr[13] && (int'(bus.addr[9:0]) < HMAX);
  assign unused_bits = ^bus.wr_data[DATA_W-1:TGT_W+1];

  // A target beyond the last active line can never match; such a wait is retried each frame.
  assign target_oor = COORD_W'(target_q) >= COORD_W'(VMAX);

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    cap_we  = 1'b0;
    arm_ok  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (arm_wr) begin
        state_d = ST_ARMED;
        arm_ok  = 1'b1;
      end
      ST_ARMED: if (si_frame_start) state_d = ST_WAIT_LINE;
      ST_WAIT_LINE: begin
        if (target_oor) begin
          if (si_frame_start) state_d = ST_ARMED;
        end else if (si_valid && y == COORD_W'(target_q) && x == '0) begin
          cap_we  = 1'b1;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: if (si_valid && x < COORD_W'(HMAX)) begin
        cap_we = 1'b1;
        if (x == COORD_W'(HMAX - 1)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (clr_wr) begin
      state_d = ST_IDLE;
      cap_we  = 1'b0;
      arm_ok  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (arm_ok) begin
        target_q <= bus.wr_data[TGT_W:1];
        count_q  <= '0;
      end else if (cap_we) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

`ifdef CAPTURE_CRC_EN
  logic [15:0] crc_q;
  always_ff @(posedge clk) begin
    if (!reset)      crc_q <= '0;
    else if (arm_ok) crc_q <= CRC_INIT;
    else if (cap_we) crc_q <= crc16_step(crc_q, 16'(si_rgb));
  end
  assign crc_w = crc_q;
`else
  assign crc_w = '0;
`endif

  always_comb begin
    status_w = '0;
    status_w[ST_DONE_BIT]          = (state_q == ST_DONE);
    status_w[ST_BUSY_BIT]          = state_q inside {ST_ARMED, ST_WAIT_LINE, ST_CAPTURE};
    status_w[ST_STATE_LSB +: 3]    = state_q;
    status_w[ST_COUNT_LSB +: 10]   = 10'(count_q);
    status_w[ST_CRC_LSB +: 16]     = crc_w;
  end

  capture_line_ram #(.W(CD), .DEPTH(HMAX), .AW(IDX_W)) u_ram (
    .clk (clk),
    .we  (cap_we),
    .wa  (x[IDX_W-1:0]),
    .wd  (si_rgb),
    .re  (buf_rd),
    .ra  (bus.addr[IDX_W-1:0]),
    .rq  (buf_q)
  );

  // Register reads and the RAM port both land one cycle after cs&read; the flag picks the source.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_buf_q <= 1'b0;
      reg_rd_q <= '0;
    end else if (rd_req) begin
      rd_buf_q <= buf_rd;
      reg_rd_q <= (!bus.addr[13] && bus.addr[12:0] == REG_STATUS) ? status_w : '0;
    end
  end

  assign bus.rd_data = rd_buf_q ? DATA_W'(buf_q) : reg_rd_q;

endmodule

// File: tb/tb_chu_vga_capture_core.sv
// Randomized bench for chu_vga_capture_core against a behavioural capture model;
// build with CAPTURE_CRC_EN defined to cover the CRC variant as well.
module tb_chu_vga_capture_core;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] x, y;
  logic        si_valid, si_frame_start;
  logic [11:0] si_rgb, so_rgb;

  chu_vga_capture_core_if bus ();

  chu_vga_capture_core dut (
    .clk            (clk),
    .reset          (reset_n),
    .x              (x),
    .y              (y),
    .si_valid       (si_valid),
    .si_frame_start (si_frame_start),
    .si_rgb         (si_rgb),
    .so_rgb         (so_rgb),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int n_checks, n_err;

  // Reference model: spec-level capture state (codes 0 idle .. 4 done), buffer image, stats.
  int          m_state, m_target, m_count;
  logic [15:0] m_crc;
  logic [11:0] m_buf [640];
  logic [31:0] m_rd;

  int          ev_kind, ev_x;
  logic [31:0] ev_wd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_crc(input logic [15:0] crc, input logic [15:0] w);
    logic [15:0] c;
    c = crc ^ w;
    for (int b = 0; b < 16; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[0]    = (m_state == 4);
    s[1]    = (m_state >= 1 && m_state <= 3);
    s[4:2]  = m_state[2:0];
    s[14:5] = m_count[9:0];
`ifdef CAPTURE_CRC_EN
    s[31:16] = m_crc;
`endif
    return s;
  endfunction

  task automatic store_pixel();
    m_buf[x] = si_rgb;
    m_count++;
    m_crc = ref_crc(m_crc, {4'h0, si_rgb});
  endtask

  task automatic model_step();
    bit arm, clr;
    int off;
    if (!reset_n) begin
      m_state = 0; m_target = 0; m_count = 0; m_crc = '0; m_rd = '0;
      return;
    end
    off = int'(bus.addr[12:0]);
    if (bus.cs && bus.read) begin
      if (bus.addr[13]) m_rd = (bus.addr[9:0] < 640) ? {20'h0, m_buf[bus.addr[9:0]]} : 32'h0;
      else              m_rd = (off == 1) ? exp_status() : 32'h0;
    end
    arm = bus.cs && bus.write && !bus.addr[13] && off == 0 && bus.wr_data[0];
    clr = bus.cs && bus.write && !bus.addr[13] && off == 2;
    if (clr) begin
      m_state = 0;
      return;
    end
    case (m_state)
      0, 4: if (arm) begin
        m_state = 1; m_target = int'(bus.wr_data[10:1]); m_count = 0; m_crc = 16'hFFFF;
      end
      1: if (si_frame_start) m_state = 2;
      2: begin
        if (m_target >= 480) begin
          if (si_frame_start) m_state = 1;
        end else if (si_valid && y == m_target && x == 0) begin
          store_pixel();
          m_state = 3;
        end
      end
      3: if (si_valid && x < 640) begin
        store_pixel();
        if (x == 639) m_state = 4;
      end
      default: ;
    endcase
  endtask

  task automatic tick(input string tag);
    #1 check({tag, "/so_rgb"}, 32'(so_rgb), 32'(si_rgb));
    @(posedge clk);
    #1 model_step();
    if (bus.cs && bus.read && reset_n) check({tag, "/rd"}, bus.rd_data, m_rd);
    @(negedge clk);
  endtask

  task automatic bus_idle();
    bus.cs = 1'b0; bus.write = 1'b0; bus.read = 1'b0; bus.addr = '0; bus.wr_data = '0;
  endtask

  task automatic bus_write(input logic [13:0] a, input logic [31:0] d);
    si_valid = 1'b0; si_rgb = 12'($urandom);
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = a; bus.wr_data = d;
    tick("wr");
    bus_idle();
  endtask

  task automatic bus_read(input string tag, input logic [13:0] a);
    si_valid = 1'b0; si_rgb = 12'($urandom);
    bus.cs = 1'b1; bus.read = 1'b1; bus.addr = a;
    tick(tag);
    bus_idle();
  endtask

  task automatic arm(input int t);
    bus_write(14'd0, 32'((t << 1) | 1));
  endtask

  task automatic frame_start();
    si_valid = 1'b1; si_frame_start = 1'b1; x = '0; y = '0; si_rgb = 12'($urandom);
    tick("fs");
    si_frame_start = 1'b0; si_valid = 1'b0;
  endtask

  // mode 0: pixel = {y[3:0], x[7:0]}; 1: random; 2: all zero. Random idle bubbles in between.
  task automatic feed_line(input int yy, input int mode);
    for (int xx = 0; xx < 640; xx++) begin
      if ($urandom_range(0, 5) == 0) begin
        si_valid = 1'b0; x = 11'(xx); y = 11'(yy); si_rgb = 12'($urandom);
        tick("bubble");
      end
      si_valid = 1'b1; x = 11'(xx); y = 11'(yy);
      case (mode)
        0:       si_rgb = {yy[3:0], xx[7:0]};
        1:       si_rgb = 12'($urandom);
        default: si_rgb = 12'h000;
      endcase
      if (xx == ev_x) begin
        case (ev_kind)
          1: begin bus.cs = 1'b1; bus.write = 1'b1; bus.addr = 14'd2; bus.wr_data = $urandom; end
          2: begin bus.cs = 1'b1; bus.read = 1'b1; bus.addr = {4'b1000, xx[9:0]}; end
          3: reset_n = 1'b0;
          4: begin bus.cs = 1'b1; bus.write = 1'b1; bus.addr = 14'd0; bus.wr_data = ev_wd; end
          default: ;
        endcase
      end
      tick("pixel");
      bus_idle(); reset_n = 1'b1; si_valid = 1'b0;
    end
    ev_kind = 0; ev_x = -1;
  endtask

  initial begin
    logic [15:0] g;
    int t;
    n_checks = 0; n_err = 0;
    reset_n = 1'b0; x = '0; y = '0; si_valid = 1'b0; si_frame_start = 1'b0; si_rgb = '0;
    bus_idle();
    ev_kind = 0; ev_x = -1; ev_wd = '0;
    m_state = 0; m_target = 0; m_count = 0; m_crc = '0; m_rd = '0;
    for (int i = 0; i < 640; i++) m_buf[i] = '0;

    // Reset state
    @(negedge clk);
    tick("reset"); tick("reset");
    reset_n = 1'b1;
    check("rst_rd_data", bus.rd_data, 32'h0);
    bus_read("rst_status", 14'd1);
    check("rst_status_zero", bus.rd_data, 32'h0);

    // Line 5 of a pattern frame
    arm(5);
    bus_read("armed_status", 14'd1);
    check("armed_code", 32'(bus.rd_data[4:2]), 32'd1);
    frame_start();
    feed_line(4, 0); feed_line(5, 0); feed_line(6, 0);
    bus_read("l5_status", 14'd1);
    check("l5_done", 32'(bus.rd_data[0]), 32'd1);
    check("l5_count", 32'(bus.rd_data[14:5]), 32'd640);
    bus_read("buf10", 14'h2000 | 14'd10);
    check("buf10_val", bus.rd_data, 32'h50A);
    repeat (6) bus_read("buf_rand", 14'h2000 | 14'($urandom_range(0, 639)));

    // Arm from DONE in the middle of line 100 (target 3); line 3 before a new frame must be ignored
    ev_kind = 4; ev_x = 50; ev_wd = 32'((3 << 1) | 1);
    feed_line(100, 1);
    bus_read("midarm_status", 14'd1);
    check("midarm_code", 32'(bus.rd_data[4:2]), 32'd1);
    check("midarm_done", 32'(bus.rd_data[0]), 32'd0);
    feed_line(3, 1);
    bus_read("noframe_status", 14'd1);
    check("noframe_count", 32'(bus.rd_data[14:5]), 32'd0);
    frame_start();
    feed_line(2, 1);
    ev_kind = 2; ev_x = 10;   // buffer read colliding with the capture write of word 10
    feed_line(3, 1);
    feed_line(4, 1);
    bus_read("l3_status", 14'd1);
    check("l3_count", 32'(bus.rd_data[14:5]), 32'd640);
    check("l3_done", 32'(bus.rd_data[0]), 32'd1);
    repeat (6) bus_read("buf_rand", 14'h2000 | 14'($urandom_range(0, 639)));

    // Out-of-range target, and an arm while busy that must be ignored
    arm(500);
    frame_start();
    feed_line(1, 1);
    bus_read("oor_status", 14'd1);
    check("oor_wait_code", 32'(bus.rd_data[4:2]), 32'd2);
    arm(7);
    feed_line(7, 1);
    bus_read("busyarm_status", 14'd1);
    check("busyarm_count", 32'(bus.rd_data[14:5]), 32'd0);
    frame_start();
    bus_read("oor_back", 14'd1);
    check("oor_back_code", 32'(bus.rd_data[4:2]), 32'd1);
    check("oor_back_done", 32'(bus.rd_data[0]), 32'd0);

    // CLEAR in the middle of a capture
    bus_write(14'd2, 32'h0);
    arm(2);
    frame_start();
    ev_kind = 1; ev_x = 300;
    feed_line(2, 1);
    feed_line(3, 1);
    bus_read("clr_status", 14'd1);
    check("clr_code", 32'(bus.rd_data[4:2]), 32'd0);
    check("clr_count", 32'(bus.rd_data[14:5]), 32'd300);
    check("clr_done", 32'(bus.rd_data[0]), 32'd0);

    // All-zero line: CRC compared with a bit-serial golden value computed in the bench
    arm(4);
    frame_start();
    feed_line(4, 2); feed_line(5, 2);
    bus_read("zero_status", 14'd1);
    g = 16'hFFFF;
    for (int i = 0; i < 640; i++) g = ref_crc(g, 16'h0000);
`ifdef CAPTURE_CRC_EN
    check("zero_crc", 32'(bus.rd_data[31:16]), 32'(g));
`else
    check("zero_crc", 32'(bus.rd_data[31:16]), 32'd0);
`endif

    // Random lines with random content
    repeat (3) begin
      t = $urandom_range(1, 478);
      arm(t);
      frame_start();
      feed_line(t - 1, 1); feed_line(t, 1); feed_line(t + 1, 1);
      bus_read("rand_status", 14'd1);
      repeat (4) bus_read("buf_rand", 14'h2000 | 14'($urandom_range(0, 639)));
    end
    bus_read("unmapped_ctrl", 14'd0);
    check("unmapped_ctrl_zero", bus.rd_data, 32'h0);
    bus_read("unmapped_3", 14'd3);
    check("unmapped_3_zero", bus.rd_data, 32'h0);
    bus_read("unmapped_top", 14'h1FFF);

    // Reset in the middle of a capture
    arm(9);
    frame_start();
    feed_line(8, 1);
    ev_kind = 3; ev_x = 200;
    feed_line(9, 1);
    check("rst_mid_rd", bus.rd_data, 32'h0);
    bus_read("rst_mid_status", 14'd1);
    check("rst_mid_status_zero", bus.rd_data, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
